systolic_drain: RTL and testbench

Result-side companion to the systolic matrix multiplier. Counts out the array's settle time after a multiply is launched, then captures the full AROW×BCOL matrix of 2N-bit accumulators. Rescales each element to N-bit signed fixed point with saturation and streams the elements out in row-major order over a valid/ready interface. It sits between the array's result matrix output and the downstream activation/write-back stage.

---
 rtl/systolic_drain_if.sv | 29 ++
 rtl/systolic_drain.sv | 144 ++++++++++++++
 tb/tb_systolic_drain.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_drain_if.sv
// Result stream from the systolic drain to the activation/write-back stage.
//
// Handshake: an element transfers on every rising edge where m_valid and
// m_ready are both high. Once m_valid is raised, m_data/m_row/m_col/m_last
// stay frozen until that transfer; m_valid never drops without a transfer
// except through reset. m_ready may be driven freely and is never required
// to wait for m_valid.
interface systolic_drain_if #(
  parameter int N  = 16,
  parameter int RW = 2,
  parameter int CW = 2
);
  logic          m_valid;
  logic          m_ready;
  logic [N-1:0]  m_data;
  logic [RW-1:0] m_row;
  logic [CW-1:0] m_col;
  logic          m_last;

  modport master (
    output m_valid, m_data, m_row, m_col, m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_data, m_row, m_col, m_last,
    output m_ready
  );
endinterface

// File: rtl/systolic_drain.sv
// Waits out the systolic array settle time after a start, snapshots the
// accumulator matrix, rescales each element to saturated N-bit fixed point
// and streams the elements out row-major over a valid/ready interface.
module systolic_drain #(
  parameter int N      = 16,
  parameter int AROW   = 3,
  parameter int ACOL   = 3,
  parameter int BCOL   = 3,
  parameter int FRAC   = 8,
  parameter int SETTLE = AROW + ACOL + BCOL
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [AROW-1:0][BCOL-1:0][2*N-1:0]   sys_array,
  output logic                                 busy,
  output logic                                 sat,
  output logic                                 done,
  output logic [1:0]                           dbg_state,
  systolic_drain_if.master                     m
);
  localparam int RW   = (AROW > 1) ? $clog2(AROW) : 1;
  localparam int CW   = (BCOL > 1) ? $clog2(BCOL) : 1;
  localparam int CNTW = $clog2(SETTLE + 1);

  localparam logic [RW-1:0] ROW_END = RW'(AROW - 1);
  localparam logic [CW-1:0] COL_END = CW'(BCOL - 1);
  localparam logic          ONE_EL  = (AROW * BCOL == 1);

  // Saturation bounds expressed at accumulator width.
  localparam logic signed [2*N-1:0] SMAX = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [2*N-1:0] SMIN = {{(N+1){1'b1}}, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t                              state;
  logic [CNTW-1:0]                     cnt;
  logic [AROW-1:0][BCOL-1:0][2*N-1:0]  cap;
  logic                                clip;

  logic [RW-1:0] nxt_row;
  logic [CW-1:0] nxt_col;
  logic          nxt_last;
  logic [N:0]    nxt_conv;
  logic [N:0]    first_conv;
  logic          capture;

  // Rescale one accumulator; returns {clamped, element}.
  function automatic logic [N:0] conv(input logic [2*N-1:0] x);
    logic signed [2*N-1:0] y;
    y = $signed(x) >>> FRAC;
    if (y > SMAX)      conv = {1'b1, SMAX[N-1:0]};
    else if (y < SMIN) conv = {1'b1, SMIN[N-1:0]};
    else               conv = {1'b0, y[N-1:0]};
  endfunction

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;
  assign capture   = (state == S_WAIT) && (cnt == '0);

  // Row-major successor of the presented element and its converted value.
  always_comb begin
    nxt_col    = '0;
    nxt_row    = m.m_row;
    nxt_last   = 1'b0;
    if (m.m_col != COL_END) begin
      nxt_col = m.m_col + CW'(1);
    end else begin
      nxt_row = m.m_row + RW'(1);
    end
    nxt_last   = (nxt_row == ROW_END) && (nxt_col == COL_END);
    nxt_conv   = conv(cap[nxt_row][nxt_col]);
    first_conv = conv(sys_array[0][0]);
  end

  // Snapshot of the array, taken once at the end of the settle window.
  always_ff @(posedge clk) begin
    if (capture) cap <= sys_array;
  end

  // Control FSM with registered stream outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      clip      <= 1'b0;
      sat       <= 1'b0;
      done      <= 1'b0;
      m.m_valid <= 1'b0;
      m.m_data  <= '0;
      m.m_row   <= '0;
      m.m_col   <= '0;
      m.m_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_WAIT;
            cnt   <= CNTW'(SETTLE - 1);
            sat   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            // Element (0,0) is converted straight from the array so it is
            // presented in the same cycle the snapshot lands.
            state     <= S_STREAM;
            m.m_valid <= 1'b1;
            m.m_row   <= '0;
            m.m_col   <= '0;
            m.m_last  <= ONE_EL;
            m.m_data  <= first_conv[N-1:0];
            clip      <= first_conv[N];
          end else begin
            cnt <= cnt - CNTW'(1);
          end
        end
        S_STREAM: begin
          if (m.m_valid && m.m_ready) begin
            if (clip) sat <= 1'b1;
            if (m.m_last) begin
              state     <= S_IDLE;
              m.m_valid <= 1'b0;
              m.m_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              m.m_row  <= nxt_row;
              m.m_col  <= nxt_col;
              m.m_last <= nxt_last;
              m.m_data <= nxt_conv[N-1:0];
              clip     <= nxt_conv[N];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_drain.sv
// Bench for systolic_drain: directed scenarios plus randomized matrices,
// checked against a row-major element model and cycle-count rules.
module tb_systolic_drain;
  localparam int N      = 16;
  localparam int AROW   = 3;
  localparam int ACOL   = 3;
  localparam int BCOL   = 3;
  localparam int FRAC   = 8;
  localparam int SETTLE = AROW + ACOL + BCOL;
  localparam int RW     = 2;
  localparam int CW     = 2;
  localparam int NEL    = AROW * BCOL;
  localparam int EW     = N + RW + CW + 2;

  typedef logic [AROW-1:0][BCOL-1:0][2*N-1:0] mat_t;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  mat_t       sys_array;
  logic       busy, sat, done;
  logic [1:0] dbg_state;

  systolic_drain_if #(.N(N), .RW(RW), .CW(CW)) sif ();

  systolic_drain #(
    .N(N), .AROW(AROW), .ACOL(ACOL), .BCOL(BCOL), .FRAC(FRAC), .SETTLE(SETTLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sys_array (sys_array),
    .busy      (busy),
    .sat       (sat),
    .done      (done),
    .dbg_state (dbg_state),
    .m         (sif)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int            total = 0;
  int            bad   = 0;
  logic [EW-1:0] exp_q[$];
  bit            sat_exp   = 0;
  bit            done_due  = 0;
  bit            chk_en    = 0;
  bit            prev_hold = 0;
  logic [N-1:0]  prev_data;
  logic [RW-1:0] prev_row;
  logic [CW-1:0] prev_col;
  int            hs_cnt = 0;
  int            stalls = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference conversion: floor-divide by 2^FRAC, then clamp to N-bit signed.
  function automatic logic [N:0] model_conv(input logic [2*N-1:0] x);
    longint v, y, hi, lo;
    logic [N:0] r;
    hi = (longint'(1) << (N - 1)) - 1;
    lo = -(longint'(1) << (N - 1));
    v  = longint'($signed(x));
    y  = v >>> FRAC;
    if (y > hi)      r = {1'b1, hi[N-1:0]};
    else if (y < lo) r = {1'b1, lo[N-1:0]};
    else             r = {1'b0, y[N-1:0]};
    return r;
  endfunction

  function automatic logic [EW-1:0] model_elem(input logic [2*N-1:0] x, input int r, input int c);
    logic [N:0] cv;
    logic       last;
    cv   = model_conv(x);
    last = (r == AROW - 1) && (c == BCOL - 1);
    return {cv[N-1:0], RW'(r), CW'(c), last, cv[N]};
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (chk_en && rst) begin
      check("sat", sat, sat_exp);
      if (done_due) begin
        check("done_pulse", done, 1);
        check("busy_after_done", busy, 0);
        check("valid_after_done", sif.m_valid, 0);
        done_due = 0;
      end else begin
        check("no_stray_done", done, 0);
      end
      if (sif.m_valid) begin
        if (prev_hold) begin
          check("hold_data", sif.m_data, prev_data);
          check("hold_row", sif.m_row, prev_row);
          check("hold_col", sif.m_col, prev_col);
        end
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = exp_q[0];
          check("m_data", sif.m_data, e[EW-1 -: N]);
          check("m_row",  sif.m_row,  e[RW+CW+1 : CW+2]);
          check("m_col",  sif.m_col,  e[CW+1 : 2]);
          check("m_last", sif.m_last, e[1]);
          if (sif.m_ready) begin
            void'(exp_q.pop_front());
            hs_cnt++;
            if (e[0]) sat_exp = 1;
            if (e[1]) done_due = 1;
          end
        end
        prev_hold = !sif.m_ready;
        prev_data = sif.m_data;
        prev_row  = sif.m_row;
        prev_col  = sif.m_col;
        if (!sif.m_ready) stalls++;
      end else begin
        prev_hold = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic mat_t ident_mat();
    mat_t m;
    for (int r = 0; r < AROW; r++)
      for (int c = 0; c < BCOL; c++)
        m[r][c] = 32'((r * BCOL + c + 1) << FRAC);
    return m;
  endfunction

  function automatic mat_t sat_mat();
    mat_t m;
    m = ident_mat();
    m[0][0] = 32'h0100_0000;
    m[0][1] = 32'hFF00_0000;
    m[0][2] = 32'hFFFF_FF00;
    m[1][0] = 32'h0000_0180;
    return m;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    int   v;
    for (int r = 0; r < AROW; r++)
      for (int c = 0; c < BCOL; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          m[r][c] = $urandom();
        end else begin
          v = int'($urandom_range(0, 32'h00FF_FFFF)) - 32'h0080_0000;
          m[r][c] = 32'(v);
        end
      end
    return m;
  endfunction

  // mode 0: ready high; 1: pattern 1,0,0,1,0,1 repeating; 2: random.
  task automatic run_matrix(input mat_t mat, input int mode, input bit poke, input bit deadbeef);
    int k;
    int idx;
    bit got;
    int pat[6] = '{1, 0, 0, 1, 0, 1};
    k   = 0;
    idx = 0;
    got = 0;
    @(posedge clk); #1;
    sys_array = mat;
    start     = 1'b1;
    stalls    = 0;
    hs_cnt    = 0;
    for (int r = 0; r < AROW; r++)
      for (int c = 0; c < BCOL; c++)
        exp_q.push_back(model_elem(mat[r][c], r, c));
    @(posedge clk); #1;
    sat_exp = 0;
    start   = poke;
    check("busy_after_start", busy, 1);
    while (!got && k < 300) begin
      if (k >= SETTLE) begin
        case (mode)
          0:       sif.m_ready = 1'b1;
          1:       sif.m_ready = pat[idx % 6][0];
          default: sif.m_ready = 1'($urandom_range(0, 1));
        endcase
        idx++;
      end else begin
        sif.m_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      k++;
      if (k < SETTLE) begin
        check("wait_no_valid", sif.m_valid, 0);
        check("wait_busy", busy, 1);
      end
      if (k == SETTLE) check("valid_at_capture", sif.m_valid, 1);
      if (k >= SETTLE) begin
        if (deadbeef) sys_array = {NEL{32'hDEAD_BEEF}};
        else          sys_array = rand_mat();
      end
      if (done) begin
        got   = 1;
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("done_seen", got, 1);
    check("done_cycle", k, SETTLE + NEL + stalls);
    check("handshakes", hs_cnt, NEL);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
    check("idle_after_done", busy, 0);
  endtask

  task automatic run_abort(input mat_t mat);
    int k;
    k = 0;
    @(posedge clk); #1;
    sys_array = mat;
    start     = 1'b1;
    hs_cnt    = 0;
    stalls    = 0;
    for (int r = 0; r < AROW; r++)
      for (int c = 0; c < BCOL; c++)
        exp_q.push_back(model_elem(mat[r][c], r, c));
    @(posedge clk); #1;
    sat_exp     = 0;
    start       = 1'b0;
    sif.m_ready = 1'b1;
    while (hs_cnt < 4 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("abort_reached_4", hs_cnt, 4);
    check("abort_sat_before", sat, 1);
    #2;
    rst = 1'b0;
    #1;
    check("abort_valid", sif.m_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_sat", sat, 0);
    exp_q.delete();
    done_due  = 0;
    sat_exp   = 0;
    prev_hold = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort_no_done", done, 0);
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("abort_stays_idle", busy, 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst         = 1'b0;
    start       = 1'b0;
    sys_array   = '0;
    sif.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",    busy, 0);
    check("rst_valid",   sif.m_valid, 0);
    check("rst_data",    sif.m_data, 0);
    check("rst_row",     sif.m_row, 0);
    check("rst_col",     sif.m_col, 0);
    check("rst_last",    sif.m_last, 0);
    check("rst_sat",     sat, 0);
    check("rst_done",    done, 0);

    // Hand-computed values that pin the conversion model.
    check("pin_pos_sat", model_conv(32'h0100_0000), {1'b1, 16'h7FFF});
    check("pin_neg_sat", model_conv(32'hFF00_0000), {1'b1, 16'h8000});
    check("pin_neg_one", model_conv(32'hFFFF_FF00), {1'b0, 16'hFFFF});
    check("pin_trunc",   model_conv(32'h0000_0180), {1'b0, 16'h0001});
    check("pin_ident9",  model_conv(32'h0000_0900), {1'b0, 16'h0009});

    rst    = 1'b1;
    chk_en = 1'b1;

    run_matrix(ident_mat(), 0, 0, 0);
    check("ident_sat_clear", sat, 0);
    run_matrix(sat_mat(), 0, 0, 0);
    check("sat_held", sat, 1);
    run_matrix(ident_mat(), 1, 0, 0);
    run_matrix(ident_mat(), 0, 0, 1);
    run_matrix(sat_mat(), 2, 1, 0);
    run_abort(sat_mat());
    run_matrix(ident_mat(), 0, 0, 0);

    for (int t = 0; t < 10; t++) begin
      run_matrix(rand_mat(), int'($urandom_range(0, 2)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
